imem_loader: RTL and testbench

Boot-time writer for the byte-addressed, little-endian instruction memory. Accepts a framed byte stream (4-byte length, payload, 1-byte XOR checksum) over a valid/ready handshake and issues one byte write per accepted payload byte to the memory's write port. Holds the CPU in reset until a frame completes with a correct checksum. Sits between the host link (UART/JTAG bridge) and the instruction memory write port.

---
 rtl/imem_pkg.sv | 19 +
 rtl/imem_xor_acc.sv | 28 ++
 rtl/imem_loader.sv | 142 ++++++++++++++
 tb/tb_imem_loader.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared constants and FSM encoding for the instruction-memory boot loader.
package imem_pkg;

   localparam int unsigned IMEM_DEPTH = 256;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LEN  = 3'd1,
      ST_DATA = 3'd2,
      ST_CSUM = 3'd3,
      ST_DONE = 3'd4,
      ST_ERR  = 3'd5
   } state_e;

   function automatic logic is_rx_state(input state_e st);
      return (st == ST_LEN) || (st == ST_DATA) || (st == ST_CSUM);
   endfunction

endpackage

// File: rtl/imem_xor_acc.sv
// 8-bit running XOR over accepted frame bytes; clear takes priority over enable.
module imem_xor_acc (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr_i,
   input  logic       en_i,
   input  logic [7:0] data_i,
   output logic [7:0] acc_o
);

   logic [7:0] acc_q;

   // Accumulator register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= 8'h00;
      end else if (clr_i) begin
         acc_q <= 8'h00;
      end else if (en_i) begin
         acc_q <= acc_q ^ data_i;
      end else begin
         acc_q <= acc_q;
      end
   end

   assign acc_o = acc_q;

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: receives a length/payload/XOR-checksum frame and writes the
// payload byte by byte into instruction memory, releasing the CPU on success.
module imem_loader
   import imem_pkg::*;
#(
   parameter int unsigned DEPTH = IMEM_DEPTH
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   input  logic        reload,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [7:0]  mem_wdata,
   output logic        cpu_reset_n,
   output logic        done,
   output logic        error
);

   localparam logic [31:0] DEPTH_W = 32'(DEPTH);

   state_e      state_q;
   logic [31:0] len_q;
   logic [31:0] len_d;
   logic [31:0] cnt_q;
   logic        mem_we_q;
   logic [31:0] mem_addr_q;
   logic [7:0]  mem_wdata_q;
   logic        cpu_reset_n_q;
   logic        done_q;
   logic        error_q;

   logic        accept_s;
   logic        restart_s;
   logic        acc_clr_s;
   logic        acc_en_s;
   logic [7:0]  acc_s;

   assign in_ready  = is_rx_state(state_q);
   assign accept_s  = in_valid && in_ready;
   assign restart_s = ((state_q == ST_DONE) || (state_q == ST_ERR)) && reload;
   // Length arrives LSB first, so shift new bytes in from the top.
   assign len_d     = {in_data, len_q[31:8]};

   assign acc_clr_s = (state_q == ST_IDLE) || restart_s;
   assign acc_en_s  = accept_s && ((state_q == ST_LEN) || (state_q == ST_DATA));

   imem_xor_acc u_xor_acc (
      .clk    (clk),
      .rst_n  (reset),
      .clr_i  (acc_clr_s),
      .en_i   (acc_en_s),
      .data_i (in_data),
      .acc_o  (acc_s)
   );

   // Frame FSM with length register, byte counter and registered write port
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         len_q         <= 32'd0;
         cnt_q         <= 32'd0;
         mem_we_q      <= 1'b0;
         mem_addr_q    <= 32'd0;
         mem_wdata_q   <= 8'h00;
         cpu_reset_n_q <= 1'b0;
         done_q        <= 1'b0;
         error_q       <= 1'b0;
      end else begin
         mem_we_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               state_q <= ST_LEN;
               cnt_q   <= 32'd0;
            end
            ST_LEN: begin
               if (accept_s) begin
                  len_q <= len_d;
                  if (cnt_q == 32'd3) begin
                     cnt_q <= 32'd0;
                     if (len_d > DEPTH_W) begin
                        state_q <= ST_ERR;
                        error_q <= 1'b1;
                     end else if (len_d == 32'd0) begin
                        state_q <= ST_CSUM;
                     end else begin
                        state_q <= ST_DATA;
                     end
                  end else begin
                     cnt_q <= cnt_q + 32'd1;
                  end
               end
            end
            ST_DATA: begin
               if (accept_s) begin
                  mem_we_q    <= 1'b1;
                  mem_addr_q  <= cnt_q;
                  mem_wdata_q <= in_data;
                  cnt_q       <= cnt_q + 32'd1;
                  if (cnt_q == (len_q - 32'd1)) begin
                     state_q <= ST_CSUM;
                  end
               end
            end
            ST_CSUM: begin
               if (accept_s) begin
                  if (in_data == acc_s) begin
                     state_q       <= ST_DONE;
                     done_q        <= 1'b1;
                     cpu_reset_n_q <= 1'b1;
                  end else begin
                     state_q <= ST_ERR;
                     error_q <= 1'b1;
                  end
               end
            end
            ST_DONE, ST_ERR: begin
               if (reload) begin
                  state_q       <= ST_LEN;
                  cnt_q         <= 32'd0;
                  done_q        <= 1'b0;
                  error_q       <= 1'b0;
                  cpu_reset_n_q <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign cpu_reset_n = cpu_reset_n_q;
   assign done        = done_q;
   assign error       = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected memory writes go into a scoreboard
// queue that a negedge monitor drains; status outputs are checked per frame.
module tb_imem_loader;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        reload;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        cpu_reset_n;
   logic        done;
   logic        error;

   int checks;
   int errors;

   typedef struct packed {
      logic [31:0] addr;
      logic [7:0]  data;
   } wr_t;

   wr_t exp_q[$];

   imem_loader dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .reload      (reload),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .cpu_reset_n (cpu_reset_n),
      .done        (done),
      .error       (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   // Write-port monitor
   always @(negedge clk) begin
      if (reset && mem_we) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_we: got addr=%0h data=%0h, expected no write", mem_addr, mem_wdata);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            if (mem_addr !== e.addr || mem_wdata !== e.data) begin
               errors++;
               $display("FAIL mem_write: got addr=%0h data=%0h, expected addr=%0h data=%0h",
                        mem_addr, mem_wdata, e.addr, e.data);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit thr);
      int n;
      if (thr && ($urandom_range(0, 1) == 1)) begin
         in_valid = 1'b0;
         repeat ($urandom_range(1, 3)) @(posedge clk);
         #1;
      end
      in_valid = 1'b1;
      in_data  = b;
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout: got in_ready=0 expected 1 for byte %0h", b);
      end else begin
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic send_len(input logic [31:0] len, input bit thr);
      for (int i = 0; i < 4; i++) begin
         send_byte(len[8*i +: 8], thr);
      end
   endtask

   task automatic send_data(input logic [7:0] b, input int addr, input bit thr);
      wr_t w;
      w.addr = 32'(addr);
      w.data = b;
      exp_q.push_back(w);
      send_byte(b, thr);
   endtask

   task automatic good_frame(input logic [7:0] cs, input bit thr);
      send_len(32'd4, thr);
      send_data(8'h13, 0, thr);
      send_data(8'h05, 1, thr);
      send_data(8'hA0, 2, thr);
      send_data(8'h00, 3, thr);
      send_byte(cs, thr);
   endtask

   task automatic check_end(input string tag, input bit exp_done, input bit exp_err);
      chk({tag, "_done"}, {31'd0, done}, {31'd0, exp_done});
      chk({tag, "_error"}, {31'd0, error}, {31'd0, exp_err});
      chk({tag, "_cpu_reset_n"}, {31'd0, cpu_reset_n}, {31'd0, exp_done});
      chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      chk({tag, "_writes_drained"}, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic do_reload(input string tag);
      reload = 1'b1;
      @(posedge clk);
      #1;
      reload = 1'b0;
      chk({tag, "_reload_done"}, {31'd0, done}, 32'd0);
      chk({tag, "_reload_error"}, {31'd0, error}, 32'd0);
      chk({tag, "_reload_cpu"}, {31'd0, cpu_reset_n}, 32'd0);
      chk({tag, "_reload_ready"}, {31'd0, in_ready}, 32'd1);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
      chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
      chk({tag, "_mem_addr"}, mem_addr, 32'd0);
      chk({tag, "_mem_wdata"}, {24'd0, mem_wdata}, 32'd0);
      chk({tag, "_cpu_reset_n"}, {31'd0, cpu_reset_n}, 32'd0);
      chk({tag, "_done"}, {31'd0, done}, 32'd0);
      chk({tag, "_error"}, {31'd0, error}, 32'd0);
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      reset    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      reload   = 1'b0;
      #2;
      check_reset_vals("por");
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("idle_in_ready", {31'd0, in_ready}, 32'd0);

      // Good frame
      good_frame(8'hB2, 1'b0);
      check_end("good", 1'b1, 1'b0);

      // Host presenting data while not ready has no effect
      in_valid = 1'b1;
      in_data  = 8'h55;
      repeat (3) @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("hold_done", {31'd0, done}, 32'd1);

      // Bad checksum: writes still happen
      do_reload("bad");
      good_frame(8'hB3, 1'b0);
      check_end("bad", 1'b0, 1'b1);

      // Oversize length 257
      do_reload("over");
      send_len(32'd257, 1'b0);
      check_end("over", 1'b0, 1'b1);

      // Zero length, correct then wrong checksum
      do_reload("zero_ok");
      send_len(32'd0, 1'b0);
      send_byte(8'h00, 1'b0);
      check_end("zero_ok", 1'b1, 1'b0);
      do_reload("zero_bad");
      send_len(32'd0, 1'b0);
      send_byte(8'h01, 1'b0);
      check_end("zero_bad", 1'b0, 1'b1);

      // Throttled host
      do_reload("thr");
      good_frame(8'hB2, 1'b1);
      check_end("thr", 1'b1, 1'b0);

      // Reset in the middle of DATA
      do_reload("mid");
      send_len(32'd4, 1'b0);
      send_data(8'h13, 0, 1'b0);
      send_data(8'h05, 1, 1'b0);
      @(negedge clk);
      #1;
      reset = 1'b0;
      #1;
      check_reset_vals("midrst");
      chk("midrst_drained", 32'(exp_q.size()), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      check_reset_vals("midrst_hold");
      reset = 1'b1;
      good_frame(8'hB2, 1'b0);
      check_end("after_rst", 1'b1, 1'b0);

      // Reload from ERR then good frame
      do_reload("err1");
      good_frame(8'h00, 1'b0);
      check_end("err1", 1'b0, 1'b1);
      do_reload("err2");
      good_frame(8'hB2, 1'b0);
      check_end("err2", 1'b1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
